// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the multi-lane SPI slave transmitter.
// Lane modes, FSM states, reset target and the bits-per-edge lookup.
package spi_slave_pkg;

  typedef enum logic [1:0] {
    SPI_STD  = 2'b00,
    SPI_DUAL = 2'b01,
    SPI_QUAD = 2'b10
  } spi_mode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } spi_state_e;

  localparam int unsigned CNT_TRGT_RST = 7;
  localparam int unsigned NUM_LANES    = 4;

  function automatic int unsigned spi_bpe(spi_mode_e m);
    case (m)
      SPI_DUAL: return 2;
      SPI_QUAD: return 4;
      default:  return 1;
    endcase
  endfunction

  // Reserved encoding 2'b11 falls back to single-lane operation.
  function automatic spi_mode_e spi_mode_decode(logic [1:0] m);
    return (m == 2'b11) ? SPI_STD : spi_mode_e'(m);
  endfunction

endpackage

// File: rtl/pulp_clock_cells.sv
// Behavioural models of the pulp clock inverter and 2:1 clock mux cells.
// Replaced by the technology cells at implementation.
module pulp_clock_inverter (
  input  logic clk_i,
  output logic clk_o
);
  assign clk_o = ~clk_i;
endmodule

module pulp_clock_mux2 (
  input  logic clk0_i,
  input  logic clk1_i,
  input  logic clk_sel_i,
  output logic clk_o
);
  assign clk_o = clk_sel_i ? clk1_i : clk0_i;
endmodule

// File: rtl/spi_slave_tx_fifo.sv
// Prefetch FIFO for transmit words; read data is zero whenever empty so an
// underrun reload shifts out zeros. Pointers clear asynchronously on rst.
module spi_slave_tx_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wptr_q, rptr_q;

  // Extra pointer bit distinguishes full from empty.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rdata = empty ? '0 : mem[rptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push && !full) wptr_q <= wptr_q + 1'b1;
      if (pop && !empty) rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/spi_slave_tx_mq.sv
// SPI slave transmitter with single/dual/quad lanes, edge-counted transfers
// and a small prefetch buffer. Chip-select high acts as asynchronous reset.
module spi_slave_tx_mq
  import spi_slave_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic              sclk,
  input  logic              cs,
  input  logic              test_mode,
  input  logic [1:0]        mode_i,
  input  logic [CNT_W-1:0]  counter_in,
  input  logic              counter_in_upd,
  input  logic [DATA_W-1:0] data_i,
  input  logic              data_valid_i,
  output logic              data_ready_o,
  output logic [3:0]        sdo,
  output logic [3:0]        sdo_oe,
  output logic              done_o,
  output logic              underrun_o
);
  localparam int unsigned BEAT_W = $clog2(DATA_W);

  logic              sclk_n, sclk_test;
  spi_state_e        state_q, state_d;
  spi_mode_e         mode_q;
  logic [CNT_W-1:0]  counter_q, counter_trgt_q;
  logic [BEAT_W-1:0] beat_q, beat_last;
  logic [DATA_W-1:0] shreg_q, fifo_rdata;
  logic              underrun_q;
  logic              fifo_full, fifo_empty;
  logic              push, pop, last_edge, shift_en, reload;

  // Functional mode launches on the falling sclk edge; scan uses sclk as-is.
  pulp_clock_inverter i_clk_inv (.clk_i(sclk), .clk_o(sclk_n));
  pulp_clock_mux2 i_clk_mux (
    .clk0_i   (sclk_n),
    .clk1_i   (sclk),
    .clk_sel_i(test_mode),
    .clk_o    (sclk_test)
  );

  assign data_ready_o = !fifo_full && !cs;
  assign push         = data_valid_i && data_ready_o;
  assign last_edge    = (state_q == ST_SHIFT) && (counter_q == counter_trgt_q);
  assign shift_en     = (state_q == ST_SHIFT) && !last_edge && !counter_in_upd;
  assign beat_last    = BEAT_W'(DATA_W / spi_bpe(mode_q) - 1);
  assign reload       = shift_en && (beat_q == beat_last);
  assign pop          = counter_in_upd || reload;
  assign underrun_o   = underrun_q;

  spi_slave_tx_fifo #(.DATA_W(DATA_W), .DEPTH(BUF_DEPTH)) i_fifo (
    .clk  (sclk_test),
    .rst  (cs),
    .push (push),
    .pop  (pop),
    .wdata(data_i),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_ff @(posedge sclk_test or posedge cs) begin
    if (cs) state_q <= ST_IDLE;
    else    state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (counter_in_upd) state_d = ST_SHIFT;
    else if (last_edge) state_d = ST_IDLE;
  end

  always_comb begin
    done_o = last_edge;
    sdo    = '0;
    sdo_oe = '0;
    if (state_q == ST_SHIFT) sdo_oe = 4'((32'd1 << spi_bpe(mode_q)) - 32'd1);
    case (mode_q)
      SPI_DUAL: sdo[1:0] = shreg_q[DATA_W-1 -: 2];
      SPI_QUAD: sdo      = shreg_q[DATA_W-1 -: 4];
      default:  sdo[0]   = shreg_q[DATA_W-1];
    endcase
  end

  always_ff @(posedge sclk_test or posedge cs) begin
    if (cs) begin
      counter_q      <= '0;
      counter_trgt_q <= CNT_W'(CNT_TRGT_RST);
      beat_q         <= '0;
      shreg_q        <= '0;
      mode_q         <= SPI_STD;
    end else if (counter_in_upd) begin
      counter_trgt_q <= counter_in;
      mode_q         <= spi_mode_decode(mode_i);
      counter_q      <= '0;
      beat_q         <= '0;
      shreg_q        <= fifo_rdata;
    end else if (last_edge) begin
      counter_q <= '0;
    end else if (shift_en) begin
      counter_q <= counter_q + 1'b1;
      if (reload) begin
        shreg_q <= fifo_rdata;
        beat_q  <= '0;
      end else begin
        beat_q <= beat_q + 1'b1;
        case (mode_q)
          SPI_DUAL: shreg_q <= {shreg_q[DATA_W-3:0], 2'b00};
          SPI_QUAD: shreg_q <= {shreg_q[DATA_W-5:0], 4'b0000};
          default:  shreg_q <= {shreg_q[DATA_W-2:0], 1'b0};
        endcase
      end
    end
  end

  // Empty pops (start or reload) leave a sticky flag until chip-select.
  always_ff @(posedge sclk_test or posedge cs) begin
    if (cs)                     underrun_q <= 1'b0;
    else if (pop && fifo_empty) underrun_q <= 1'b1;
  end

endmodule

// File: doc/spi_slave_tx_mq.md
SPI_SLAVE_TX_MQ -- requirements
Module: spi_slave_tx_mq

Interface
REQ-001 Parameter DATA_W, default 32, word width; SHALL be a multiple of 4 and at least 8.
REQ-002 Parameter CNT_W, default 8, width of the edge counter and target.
REQ-003 Parameter BUF_DEPTH, default 2, number of prefetch buffer entries; SHALL be a power of 2 and at least 2.
REQ-004 sclk  in  1  the single clock; all state advances on the internal clock derived from it (REQ-009).
REQ-005 cs  in  1  reset, asynchronous and active-high: chip-select deasserted.
REQ-006 test_mode  in  1  1 selects non-inverted sclk for scan.
REQ-007 mode_i  in  2  lane mode: 00 single (1 bit/edge), 01 dual (2), 10 quad (4), 11 reserved, treated as single.
REQ-008 Other ports SHALL be:
- counter_in  in  CNT_W  last edge index of the transfer.
- counter_in_upd  in  1  start or restart pulse.
- data_i  in  DATA_W  word to transmit.
- data_valid_i  in  1  data_i valid.
- data_ready_o  out  1  buffer can accept a word.
- sdo  out  4  data lanes.
- sdo_oe  out  4  lane output enables.
- done_o  out  1  final-edge pulse.
- underrun_o  out  1  sticky: a shift register reload found the buffer empty.

Function
REQ-009 Internal clock SHALL be ~sclk when test_mode=0 and sclk when test_mode=1, so data launches on the falling edge in functional mode.
REQ-010 BPE (bits per edge) SHALL be 1, 2 or 4 from the latched mode; beats per word SHALL be DATA_W/BPE.
REQ-011 Buffer push SHALL occur when data_valid_i && data_ready_o; data_ready_o SHALL equal !full && !cs.
REQ-012 Buffer order SHALL be FIFO.
REQ-013 Buffer SHALL have no bypass: a pop on an empty buffer yields all-zero data and sets underrun_o, even if a push occurs in the same cycle.
REQ-014 FSM states SHALL be IDLE and SHIFT.
REQ-015 IDLE: counter, shift register and outputs SHALL hold; pushes are still accepted.
REQ-016 counter_in_upd in any state SHALL have top priority and SHALL:
- latch counter_trgt <= counter_in and mode_q <= mode_i;
- set counter <= 0 and beat <= 0;
- pop the buffer head into the shift register;
- enter SHIFT.
REQ-017 SHIFT, per edge with counter != counter_trgt:
- counter increments by 1;
- shift register shifts left by BPE, zero fill;
- beat increments; when beat reaches DATA_W/BPE-1 the next edge pops a new word into the shift register and beat wraps to 0.
REQ-018 SHIFT with counter == counter_trgt: done_o SHALL be 1 combinationally in that cycle; counter SHALL become 0 and the FSM SHALL go to IDLE.
REQ-019 A counter_in_upd in the cycle of REQ-018 SHALL restart per REQ-016, and done_o SHALL still pulse.
REQ-020 Lane mapping, with MSB as the shift register top bit:
- single: sdo[0]=MSB;
- dual: sdo[1:0]=MSB..MSB-1;
- quad: sdo[3:0]=MSB..MSB-3;
- unused lanes SHALL be 0.
REQ-021 sdo_oe SHALL be 0001/0011/1111 per mode_q in SHIFT, and 0000 in IDLE.
REQ-022 Counter arithmetic SHALL be CNT_W bits; counter_trgt=0 SHALL give a one-edge transfer.
REQ-023 underrun_o SHALL clear only on cs.

Reset
REQ-024 While cs=1, the following SHALL hold at their reset values:
- counter=0, counter_trgt=7, beat=0;
- shift register=0, buffer empty, mode_q=single;
- FSM=IDLE;
- sdo=0, sdo_oe=0, done_o=0, underrun_o=0, data_ready_o=0.
REQ-025 cs asserting mid-transfer SHALL abort it immediately with no done_o and SHALL discard buffered words.

Structure
REQ-026 spi_slave_pkg SHALL hold:
- spi_mode_e (SPI_STD, SPI_DUAL, SPI_QUAD);
- the BPE lookup function;
- the counter_trgt reset constant 7.
REQ-027 The FIFO SHALL be sub-module spi_slave_tx_fifo: push/pop, full/empty, asynchronous clear on cs.
REQ-028 Clock inversion and mux SHALL use the pulp clock inverter and mux2 cells.

Verification
REQ-029 Single mode: push 0xA5000000, pulse upd with counter_in=7 -> sdo[0]=1,0,1,0,0,1,0,1 over 8 edges, done_o on edge 8, sdo_oe=0001.
REQ-030 Quad mode: push 0x12345678, upd with counter_in=7 -> sdo=1,2,...,8 over 8 edges, sdo_oe=1111, done_o on the last edge.
REQ-031 Dual mode: two words 0xFFFFFFFF and 0x00000000 buffered, counter_in=31 -> lanes=11 for 16 edges then 00 for 16 edges, underrun_o=0.
REQ-032 Underrun: single mode, one word buffered, counter_in=39 -> edges 33-40 drive 0, underrun_o=1 from the reload edge onward.
REQ-033 Backpressure: with BUF_DEPTH=2, 2 pushes in IDLE -> data_ready_o=0; a 3rd valid word is held until a pop.
REQ-034 Abort: cs=1 at edge 5 of a quad transfer -> all outputs 0 asynchronously, no done_o; a fresh transfer after cs=0 behaves per REQ-030.
